// File: rtl/tmr_state_reg_voted.sv
// Triplicated WIDTH-bit state register with per-copy majority voters, continuous scrubbing,
// hold/XOR/add/load update modes, mismatch flags, a saturating error counter and fault injection.
module tmr_state_reg_voted #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     din,
   input  logic                 clr_err,
   input  logic [1:0]           inj_sel,
   input  logic [WIDTH-1:0]     inj_mask,
   output logic [WIDTH-1:0]     dout,
   output logic                 err_any,
   output logic [2:0]           err_copy,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_XOR  = 2'b01,
      MODE_ADD  = 2'b10,
      MODE_LOAD = 2'b11
   } modeT;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]     copyQ [3];
   logic [WIDTH-1:0]     voted;
   logic [2:0]           mism;
   logic [2:0]           errCopyQ;
   logic [CNT_WIDTH-1:0] errCntQ;

   // Each copy owns a private voter and next-state path so that no single gate is shared
   // between the three copies.
   for (genvar i = 0; i < 3; i++) begin : gCopy
      logic [WIDTH-1:0] voteLocal;
      logic [WIDTH-1:0] nxtLocal;
      logic [WIDTH-1:0] stateQ;

      assign voteLocal = (copyQ[0] & copyQ[1]) | (copyQ[1] & copyQ[2]) | (copyQ[0] & copyQ[2]);

      // NOTE: combinational blocks assign a default first so every path drives the output (no latch).
      always_comb begin
         nxtLocal = voteLocal;
         if (en) begin
            case (modeT'(mode))
               MODE_XOR:  nxtLocal = voteLocal ^ din;
               MODE_ADD:  nxtLocal = voteLocal + din;
               MODE_LOAD: nxtLocal = din;
               default:   nxtLocal = voteLocal;
            endcase
         end
      end

      // NOTE: state uses non-blocking assignments so all copies sample the same pre-edge vote.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            stateQ <= RESET_VAL;
         end else if (inj_sel == 2'(i)) begin
            stateQ <= nxtLocal ^ inj_mask;
         end else begin
            stateQ <= nxtLocal;
         end
      end

      assign copyQ[i] = stateQ;
   end

   // Observation voter: drives dout and the mismatch detectors only, never the feedback.
   assign voted = (copyQ[0] & copyQ[1]) | (copyQ[1] & copyQ[2]) | (copyQ[0] & copyQ[2]);
   assign dout  = voted;

   for (genvar i = 0; i < 3; i++) begin : gMism
      assign mism[i] = |(copyQ[i] ^ voted);
   end

   assign err_any = |mism;

   // A mismatch seen in the clearing cycle survives the clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         errCopyQ <= '0;
      end else if (clr_err) begin
         errCopyQ <= mism;
      end else begin
         errCopyQ <= errCopyQ | mism;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         errCntQ <= '0;
      end else if (clr_err) begin
         errCntQ <= CNT_WIDTH'(err_any);
      end else if (err_any && (errCntQ != CNT_MAX)) begin
         errCntQ <= errCntQ + 1'b1;
      end
   end

   assign err_copy = errCopyQ;
   assign err_cnt  = errCntQ;

endmodule
